tmec_chien_search: RTL

- Parallel Chien search stage directly downstream of the inversionless Berlekamp error-locator stage.
- Latches the T+1 locator coefficients c0..cT (c0 least significant in the input bus) on a start pulse. It then evaluates sigma at one field element per cycle.
- Streams one error-flag bit per codeword position, highest-order bit first, to the data-correction XOR.
- At the end of the frame, reports the root count and an uncorrectable flag.

---
 rtl/tmec_chien_search_pkg.sv | 44 ++++
 rtl/tmec_chien_search_term.sv | 19 +
 rtl/tmec_chien_search.sv | 76 +++++++
 3 files changed

// File: rtl/tmec_chien_search_pkg.sv
// tmec_chien_search_pkg: GF(2^m) constant-multiplier helpers and clog2 for the Chien search.
package tmec_chien_search_pkg;
  localparam int MAX_M = 16;
  typedef logic [MAX_M-1:0] gf_t;
  function automatic gf_t prim_poly(input int m);
    case (m)
      2: return gf_t'('h7);
      3: return gf_t'('hB);
      5: return gf_t'('h25);
      6: return gf_t'('h43);
      7: return gf_t'('h89);
      8: return gf_t'('h11D);
      9: return gf_t'('h211);
      10: return gf_t'('h409);
      11: return gf_t'('h805);
      12: return gf_t'('h1053);
      default: return gf_t'('h13);
    endcase
  endfunction
  function automatic gf_t gf_mul_alpha(input gf_t x, input int m);
    gf_t y;
    y = x << 1;
    return y[m] ? y ^ prim_poly(m) : y;
  endfunction
  function automatic gf_t gf_alpha_pow(input int e, input int m);
    gf_t y;
    y = gf_t'(1);
    for (int n = 0; n < e % ((1 << m) - 1); n++) y = gf_mul_alpha(y, m);
    return y;
  endfunction
  // x * alpha^e as the XOR of constant matrix columns alpha^(e+j) selected by x[j]
  function automatic gf_t gf_const_mul(input gf_t x, input int e, input int m);
    gf_t acc;
    acc = '0;
    for (int j = 0; j < m; j++) acc ^= x[j] ? gf_alpha_pow(e + j, m) : '0;
    return acc;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int n = 0; n < 32; n++) r = ((1 << r) < v) ? r + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/tmec_chien_search_term.sv
// tmec_chien_search_term: one Chien term register, loaded with c*alpha^I and stepped by alpha^I.
module tmec_chien_search_term
  import tmec_chien_search_pkg::*;
#(
  parameter int M = 4,
  parameter int I = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [M-1:0] c,
  output logic [M-1:0] r
);
  always_ff @(posedge clk)
    if (reset) r <= '0;
    else if (load) r <= M'(gf_const_mul(gf_t'(c), I, M));
    else if (step) r <= M'(gf_const_mul(gf_t'(r), I, M));
endmodule

// File: rtl/tmec_chien_search.sv
// tmec_chien_search: parallel Chien search streaming one error flag per codeword bit, MSB first.
module tmec_chien_search
  import tmec_chien_search_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 3,
  parameter int LEN = (1 << M) - 1,
  localparam int CW = clog2(T + 2),
  localparam int KW = clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [M*(T+1)-1:0] cNin,
  output logic             busy,
  output logic             err_valid,
  output logic             err,
  output logic             first,
  output logic             last,
  output logic [CW-1:0]    err_count,
  output logic             fail
);
  logic [M-1:0] r [T+1];
  logic [M-1:0] s;
  logic [KW-1:0] k;
  logic [CW-1:0] deg, deg_in, cnt_next;
  logic load, hit, at_end;
  assign load = start && !busy;
  genvar i;
  for (i = 0; i <= T; i++) begin : g_term
    tmec_chien_search_term #(.M(M), .I(i)) u_term (
      .clk(clk), .reset(reset), .load(load), .step(busy), .c(cNin[i*M +: M]), .r(r[i])
    );
  end
  always_comb begin
    s = '0;
    deg_in = '0;
    for (int j = 0; j <= T; j++) begin
      s ^= r[j];
      deg_in = (cNin[j*M +: M] != '0) ? CW'(j) : deg_in;
    end
    hit = (s == '0);
    at_end = (k == KW'(LEN - 1));
    cnt_next = (err_count == CW'(T + 1)) ? err_count : err_count + CW'(hit);
  end
  always_ff @(posedge clk)
    if (reset) begin
      busy <= 1'b0;
      err_valid <= 1'b0;
      err <= 1'b0;
      first <= 1'b0;
      last <= 1'b0;
      err_count <= '0;
      fail <= 1'b0;
      k <= '0;
      deg <= '0;
    end else begin
      err_valid <= busy;
      err <= busy && hit;
      first <= busy && (k == '0);
      last <= busy && at_end;
      if (load) begin
        busy <= 1'b1;
        k <= '0;
        err_count <= '0;
        fail <= 1'b0;
        deg <= deg_in;
      end else if (busy) begin
        busy <= !at_end;
        k <= k + KW'(1);
        err_count <= cnt_next;
        // a sigma of degree d is correctable only if exactly d roots fell inside the window
        if (at_end) fail <= (cnt_next != deg);
      end
    end
endmodule
